// File: rtl/osc_bank_pkg.sv
// osc_bank_pkg: wave modes, config word field offsets and noise LFSR constants
package osc_bank_pkg;
  typedef enum logic [1:0] {MODE_SAW, MODE_SQUARE, MODE_TRI, MODE_NOISE} wave_mode_e;
  localparam int MANT_LSB = 0;
  localparam int MODE_LSB = 13;
  localparam int RETRIG_BIT = 15;
  localparam logic [14:0] LFSR_SEED = 15'h0001;
  localparam logic [14:0] LFSR_TAPS = 15'h6000;
  function automatic logic [14:0] lfsr_step(input logic [14:0] s);
    return {s[13:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/osc_bank_if.sv
// osc_bank_if: config write port and registered sample stream of the oscillator bank
interface osc_bank_if #(
  parameter int WAVE_BITS = 4
);
  logic cfg_we;
  logic [2:0] cfg_addr;
  logic [15:0] cfg_wdata;
  logic out_valid;
  logic [2:0] out_index;
  logic [WAVE_BITS-1:0] out_wave;
  modport master (output cfg_we, cfg_addr, cfg_wdata, input out_valid, out_index, out_wave);
  modport slave (input cfg_we, cfg_addr, cfg_wdata, output out_valid, out_index, out_wave);
endinterface

// File: rtl/osc_wave_shaper.sv
// osc_wave_shaper: maps mode and phase to an unsigned sample; noise input exists only with OSC_BANK_NOISE_EN
module osc_wave_shaper
  import osc_bank_pkg::*;
#(
  parameter int WAVE_BITS = 4
) (
  input wave_mode_e mode,
  input logic [WAVE_BITS-1:0] phase,
`ifdef OSC_BANK_NOISE_EN
  input logic [WAVE_BITS-1:0] noise,
`endif
  output logic [WAVE_BITS-1:0] wave
);
  logic [WAVE_BITS-1:0] dbl, alt;
  // mode 3 falls back to the saw ramp when the noise source is compiled out
  always_comb begin
    dbl = phase << 1;
`ifdef OSC_BANK_NOISE_EN
    alt = noise;
`else
    alt = phase;
`endif
    wave = mode == MODE_SAW ? phase :
           mode == MODE_SQUARE ? {WAVE_BITS{phase[WAVE_BITS-1]}} :
           mode == MODE_TRI ? (phase[WAVE_BITS-1] ? ~dbl : dbl) : alt;
  end
endmodule

// File: rtl/osc_bank.sv
// osc_bank: time-multiplexed octave/period oscillator bank; OSC_BANK_NOISE_EN adds the shared LFSR noise mode
module osc_bank
  import osc_bank_pkg::*;
#(
  parameter int NUM_OSCS = 4,
  parameter int OCT_BITS = 4,
  parameter int PERIOD_BITS = 10,
  parameter int WAVE_BITS = 4
) (
  input logic clk,
  input logic reset,
  osc_bank_if.slave bus
);
  localparam int SW = NUM_OSCS > 1 ? $clog2(NUM_OSCS) : 1;
  localparam int SLOTS = 1 << $clog2(NUM_OSCS);
  localparam int DW = (1 << OCT_BITS) - 2;
  localparam int MW = PERIOD_BITS - 1;
  logic [SW-1:0] slot, sidx, cidx;
  logic [DW-1:0] d;
  wave_mode_e mode [NUM_OSCS];
  logic [OCT_BITS-1:0] oct [NUM_OSCS];
  logic [MW-1:0] mant [NUM_OSCS];
  logic [PERIOD_BITS-1:0] cnt [NUM_OSCS];
  logic [WAVE_BITS-1:0] ph [NUM_OSCS];
  logic act, en, trig, wr, clr;
  logic [PERIOD_BITS-1:0] cnt_nx;
  logic [WAVE_BITS-1:0] ph_nx, ph_out, wave;
`ifdef OSC_BANK_NOISE_EN
  logic [14:0] lfsr, lfsr_nx;
`endif
  // current slot decode, octave gate and the slot channel's next counter/phase
  always_comb begin
    act = int'(slot) < NUM_OSCS;
    sidx = act ? slot : '0;
    en = act && oct[sidx] != '1 && &(d | ({DW{1'b1}} << oct[sidx]));
    trig = en && cnt[sidx] == '0;
    cnt_nx = trig ? {1'b1, mant[sidx]} - 1'b1 : cnt[sidx] - 1'b1;
    ph_nx = ph[sidx] + WAVE_BITS'(trig);
    wr = bus.cfg_we && int'(bus.cfg_addr) < NUM_OSCS;
    cidx = bus.cfg_addr[SW-1:0];
    clr = wr && bus.cfg_wdata[RETRIG_BIT] && cidx == sidx;
    ph_out = clr ? '0 : ph_nx;
`ifdef OSC_BANK_NOISE_EN
    lfsr_nx = trig && mode[sidx] == MODE_NOISE ? lfsr_step(lfsr) : lfsr;
`endif
  end
  osc_wave_shaper #(.WAVE_BITS(WAVE_BITS)) u_shaper (
    .mode(mode[sidx]),
    .phase(ph_out),
`ifdef OSC_BANK_NOISE_EN
    .noise(lfsr_nx[WAVE_BITS-1:0]),
`endif
    .wave(wave)
  );
  // slot/divider sequencing, channel state, config writes (retrig wins) and the registered sample
  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
      d <= '0;
      bus.out_valid <= 1'b0;
      bus.out_index <= '0;
      bus.out_wave <= '0;
`ifdef OSC_BANK_NOISE_EN
      lfsr <= LFSR_SEED;
`endif
      for (int i = 0; i < NUM_OSCS; i++) begin
        mode[i] <= MODE_NOISE;
        oct[i] <= '1;
        mant[i] <= '1;
        cnt[i] <= '0;
        ph[i] <= '0;
      end
    end else begin
      slot <= slot == SW'(SLOTS - 1) ? '0 : slot + 1'b1;
      if (slot == SW'(SLOTS - 1)) d <= d + 1'b1;
      if (en) begin
        cnt[sidx] <= cnt_nx;
        ph[sidx] <= ph_nx;
      end
      if (wr) begin
        mant[cidx] <= bus.cfg_wdata[MANT_LSB +: MW];
        oct[cidx] <= bus.cfg_wdata[MANT_LSB + MW +: OCT_BITS];
        mode[cidx] <= wave_mode_e'(bus.cfg_wdata[MODE_LSB +: 2]);
        if (bus.cfg_wdata[RETRIG_BIT]) begin
          cnt[cidx] <= '0;
          ph[cidx] <= '0;
        end
      end
      bus.out_valid <= act;
      if (act) begin
        bus.out_index <= 3'(slot);
        bus.out_wave <= wave;
      end
`ifdef OSC_BANK_NOISE_EN
      lfsr <= lfsr_nx;
`endif
    end
  end
endmodule
